// File: rtl/omnivision_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : omnivision_spi_pkg
// Description : Shared constants, parser state encoding and header check for
//               the 2-bit OmniVision serial pixel link (receive side and the
//               transmit model).
// Revision    : 1.0 - initial release
// ============================================================================
package omnivision_spi_pkg;

  localparam logic [7:0] SYNC_FF   = 8'hFF;
  localparam logic [7:0] SYNC_00   = 8'h00;
  localparam logic [7:0] MODE_RAW8 = 8'h2A;

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    MODE   = 3'd1,
    COLS_L = 3'd2,
    COLS_H = 3'd3,
    ROWS_L = 3'd4,
    ROWS_H = 3'd5,
    DATA   = 3'd6
  } state_e;

  // A header is usable only for the raw-8 mode with a non-empty image.
  function automatic logic hdr_ok(input logic [7:0]  mode,
                                  input logic [15:0] cols,
                                  input logic [15:0] rows);
    return (mode == MODE_RAW8) && (cols != 16'd0) && (rows != 16'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/omnivision_spi_deser.sv
`default_nettype none
// ============================================================================
// Module      : omnivision_spi_deser
// Description : Oversampling front end. Synchronises sclk/sdat, detects sclk
//               rising edges, assembles four 2-bit pairs (LSB pair first) into
//               a byte and detects the end of a burst by an idle timeout.
// Revision    : 1.0 - initial release
// Ports       : clk, resetb      clock, async active-low reset
//               i_clr            drop any partial byte and suppress output
//               i_sclk, i_sdat   raw link inputs
//               o_byte           assembled byte, valid with o_byte_stb
//               o_byte_stb       one-cycle strobe per completed byte
//               o_frag_err       pulse: burst ended with 1-3 pairs pending
//               o_burst_end      pulse: IDLE_CYCLES clocks without an edge
// ============================================================================
module omnivision_spi_deser
  import omnivision_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       i_clr,
  input  logic       i_sclk,
  input  logic [1:0] i_sdat,
  output logic [7:0] o_byte,
  output logic       o_byte_stb,
  output logic       o_frag_err,
  output logic       o_burst_end
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

  logic [SYNC_STAGES-1:0]      sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0][1:0] sdat_sync_q, sdat_sync_d;
  logic                        sclk_dly_q, sclk_dly_d;
  logic [1:0]                  sdat_dly_q, sdat_dly_d;
  logic                        edge_q, edge_d;
  logic [1:0]                  k_q, k_d;
  logic [5:0]                  shreg_q, shreg_d;
  logic [7:0]                  byte_q, byte_d;
  logic                        byte_stb_q, byte_stb_d;
  logic                        frag_err_q, frag_err_d;
  logic                        burst_end_q, burst_end_d;
  logic [IDLE_W-1:0]           idle_q, idle_d;
  logic [IDLE_W-1:0]           w_idle_inc;

  assign w_idle_inc = idle_q + IDLE_W'(1);

  always_comb begin
    sclk_sync_d    = sclk_sync_q;
    sdat_sync_d    = sdat_sync_q;
    sclk_sync_d[0] = i_sclk;
    sdat_sync_d[0] = i_sdat;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sclk_sync_d[i] = sclk_sync_q[i-1];
      sdat_sync_d[i] = sdat_sync_q[i-1];
    end

    // The data delay stage keeps sdat aligned with the registered edge flag.
    sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
    sdat_dly_d  = sdat_sync_q[SYNC_STAGES-1];
    edge_d      = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;

    k_d         = k_q;
    shreg_d     = shreg_q;
    byte_d      = byte_q;
    idle_d      = idle_q;
    byte_stb_d  = 1'b0;
    frag_err_d  = 1'b0;
    burst_end_d = 1'b0;

    if (edge_q) begin
      idle_d = '0;
      if (k_q == 2'd3) begin
        byte_d     = {sdat_dly_q, shreg_q};
        byte_stb_d = ~i_clr;
        k_d        = 2'd0;
      end else begin
        shreg_d = {sdat_dly_q, shreg_q[5:2]};
        k_d     = k_q + 2'd1;
      end
    end else if (idle_q != IDLE_MAX) begin
      // Counter saturates; the burst-end pulse fires once when it arrives.
      idle_d = w_idle_inc;
      if (w_idle_inc == IDLE_MAX) begin
        burst_end_d = 1'b1;
        frag_err_d  = (k_q != 2'd0);
        k_d         = 2'd0;
      end
    end

    if (i_clr) begin
      k_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sclk_sync_q <= '0;
      sdat_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      sdat_dly_q  <= 2'd0;
      edge_q      <= 1'b0;
      k_q         <= 2'd0;
      shreg_q     <= 6'd0;
      byte_q      <= 8'd0;
      byte_stb_q  <= 1'b0;
      frag_err_q  <= 1'b0;
      burst_end_q <= 1'b0;
      idle_q      <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      sdat_sync_q <= sdat_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      sdat_dly_q  <= sdat_dly_d;
      edge_q      <= edge_d;
      k_q         <= k_d;
      shreg_q     <= shreg_d;
      byte_q      <= byte_d;
      byte_stb_q  <= byte_stb_d;
      frag_err_q  <= frag_err_d;
      burst_end_q <= burst_end_d;
      idle_q      <= idle_d;
    end
  end

  assign o_byte      = byte_q;
  assign o_byte_stb  = byte_stb_q;
  assign o_frag_err  = frag_err_q;
  assign o_burst_end = burst_end_q;

endmodule
`default_nettype wire

// File: rtl/omnivision_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : omnivision_spi_rx
// Description : Receive side of the 2-bit OmniVision serial pixel link. Locks
//               to the FF FF 00 header, decodes mode/cols/rows and regenerates
//               a parallel pixel stream with fv/lv/dv framing.
// Revision    : 1.0 - initial release
// Ports       : clk, resetb        clock, async active-low reset
//               enable             0 forces HUNT and drops fv/lv/dv
//               sclk, sdat[1:0]    serial link
//               data, dv, fv, lv   pixel stream and framing
//               mode, num_cols,    last accepted header fields
//               num_rows
//               frame_done         pulse after last pixel of a frame
//               hdr_err            pulse: rejected header
//               frag_err           pulse: burst ended inside a byte
//               row_err            pulse: burst ended mid-row
// ============================================================================
module omnivision_spi_rx
  import omnivision_spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 10,
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  enable,
  input  logic                  sclk,
  input  logic [1:0]            sdat,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  dv,
  output logic                  fv,
  output logic                  lv,
  output logic [7:0]            mode,
  output logic [15:0]           num_cols,
  output logic [15:0]           num_rows,
  output logic                  frame_done,
  output logic                  hdr_err,
  output logic                  frag_err,
  output logic                  row_err
);

  logic [7:0]  w_rx_byte;
  logic        w_byte_stb;
  logic        w_burst_end;
  logic [15:0] w_rows_full;

  omnivision_spi_deser #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_CYCLES (IDLE_CYCLES)
  ) u_deser (
    .clk         (clk),
    .resetb      (resetb),
    .i_clr       (~enable),
    .i_sclk      (sclk),
    .i_sdat      (sdat),
    .o_byte      (w_rx_byte),
    .o_byte_stb  (w_byte_stb),
    .o_frag_err  (frag_err),
    .o_burst_end (w_burst_end)
  );

  state_e                state_q, state_d;
  logic [15:0]           hist_q, hist_d;
  logic [7:0]            mode_sh_q, mode_sh_d;
  logic [15:0]           cols_sh_q, cols_sh_d;
  logic [15:0]           rows_sh_q, rows_sh_d;
  logic [7:0]            mode_q, mode_d;
  logic [15:0]           num_cols_q, num_cols_d;
  logic [15:0]           num_rows_q, num_rows_d;
  logic [15:0]           col_q, col_d;
  logic [15:0]           row_q, row_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  dv_q, dv_d;
  logic                  fv_q, fv_d;
  logic                  lv_q, lv_d;
  logic                  eol_q, eol_d;
  logic                  eof_q, eof_d;
  logic                  frame_done_q, frame_done_d;
  logic                  hdr_err_q, hdr_err_d;
  logic                  row_err_q, row_err_d;

  assign w_rows_full = {w_rx_byte, rows_sh_q[7:0]};

  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    mode_sh_d    = mode_sh_q;
    cols_sh_d    = cols_sh_q;
    rows_sh_d    = rows_sh_q;
    mode_d       = mode_q;
    num_cols_d   = num_cols_q;
    num_rows_d   = num_rows_q;
    col_d        = col_q;
    row_d        = row_q;
    data_d       = data_q;
    fv_d         = fv_q;
    lv_d         = lv_q;
    dv_d         = 1'b0;
    eol_d        = 1'b0;
    eof_d        = 1'b0;
    frame_done_d = 1'b0;
    hdr_err_d    = 1'b0;
    row_err_d    = 1'b0;

    // lv covers the last pixel of a row, then falls; fv follows one cycle
    // after the last pixel of the frame.
    if (dv_q && eol_q) begin
      lv_d = 1'b0;
    end
    if (eof_q) begin
      fv_d         = 1'b0;
      frame_done_d = 1'b1;
    end

    if (!enable) begin
      state_d = HUNT;
      hist_d  = 16'd0;
      fv_d    = 1'b0;
      lv_d    = 1'b0;
      dv_d    = 1'b0;
    end else if (w_byte_stb) begin
      case (state_q)
        HUNT: begin
          if (hist_q == {SYNC_FF, SYNC_FF} && w_rx_byte == SYNC_00) begin
            state_d = MODE;
            hist_d  = 16'd0;
          end else begin
            hist_d = {hist_q[7:0], w_rx_byte};
          end
        end
        MODE: begin
          mode_sh_d = w_rx_byte;
          state_d   = COLS_L;
        end
        COLS_L: begin
          cols_sh_d[7:0] = w_rx_byte;
          state_d        = COLS_H;
        end
        COLS_H: begin
          cols_sh_d[15:8] = w_rx_byte;
          state_d         = ROWS_L;
        end
        ROWS_L: begin
          rows_sh_d[7:0] = w_rx_byte;
          state_d        = ROWS_H;
        end
        ROWS_H: begin
          rows_sh_d = w_rows_full;
          if (hdr_ok(mode_sh_q, cols_sh_q, w_rows_full)) begin
            mode_d     = mode_sh_q;
            num_cols_d = cols_sh_q;
            num_rows_d = w_rows_full;
            fv_d       = 1'b1;
            col_d      = 16'd0;
            row_d      = 16'd0;
            state_d    = DATA;
          end else begin
            hdr_err_d = 1'b1;
            state_d   = HUNT;
          end
        end
        DATA: begin
          // Every byte here is a pixel, including FF/00 values.
          dv_d = 1'b1;
          lv_d = 1'b1;
          data_d = '0;
          data_d[DATA_WIDTH-1 -: 8] = w_rx_byte;
          if (col_q == num_cols_q - 16'd1) begin
            col_d = 16'd0;
            eol_d = 1'b1;
            if (row_q == num_rows_q - 16'd1) begin
              row_d   = 16'd0;
              eof_d   = 1'b1;
              state_d = HUNT;
            end else begin
              row_d = row_q + 16'd1;
            end
          end else begin
            col_d = col_q + 16'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end else if (w_burst_end && state_q == DATA && col_q != 16'd0) begin
      // Short row: close it and account for it as a complete row.
      row_err_d = 1'b1;
      lv_d      = 1'b0;
      col_d     = 16'd0;
      if (row_q == num_rows_q - 16'd1) begin
        row_d        = 16'd0;
        fv_d         = 1'b0;
        frame_done_d = 1'b1;
        state_d      = HUNT;
      end else begin
        row_d = row_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= HUNT;
      hist_q       <= 16'd0;
      mode_sh_q    <= 8'd0;
      cols_sh_q    <= 16'd0;
      rows_sh_q    <= 16'd0;
      mode_q       <= 8'd0;
      num_cols_q   <= 16'd0;
      num_rows_q   <= 16'd0;
      col_q        <= 16'd0;
      row_q        <= 16'd0;
      data_q       <= '0;
      dv_q         <= 1'b0;
      fv_q         <= 1'b0;
      lv_q         <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      frame_done_q <= 1'b0;
      hdr_err_q    <= 1'b0;
      row_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      mode_sh_q    <= mode_sh_d;
      cols_sh_q    <= cols_sh_d;
      rows_sh_q    <= rows_sh_d;
      mode_q       <= mode_d;
      num_cols_q   <= num_cols_d;
      num_rows_q   <= num_rows_d;
      col_q        <= col_d;
      row_q        <= row_d;
      data_q       <= data_d;
      dv_q         <= dv_d;
      fv_q         <= fv_d;
      lv_q         <= lv_d;
      eol_q        <= eol_d;
      eof_q        <= eof_d;
      frame_done_q <= frame_done_d;
      hdr_err_q    <= hdr_err_d;
      row_err_q    <= row_err_d;
    end
  end

  assign data       = data_q;
  assign dv         = dv_q;
  assign fv         = fv_q;
  assign lv         = lv_q;
  assign mode       = mode_q;
  assign num_cols   = num_cols_q;
  assign num_rows   = num_rows_q;
  assign frame_done = frame_done_q;
  assign hdr_err    = hdr_err_q;
  assign row_err    = row_err_q;

endmodule
`default_nettype wire
